dmem_loader: RTL and testbench

- Write-side initiator for the data memory port: drives `a`, `wd` and `we` of dmem, the same interface the data memory responds to.
- Accepts a byte stream through a valid/ready handshake, typically from the UART receiver.
- Assembles the bytes MSB-first into DATA_W-bit words and writes them to consecutive dmem addresses from a programmable base.
- Holds the CPU off dmem while loading, so test data such as graph tables can be loaded at run time instead of from initial blocks.

---
 rtl/dmem_loader_pkg.sv | 12 +
 rtl/dmem_loader_byte_packer.sv | 57 +++++
 rtl/dmem_loader.sv | 142 ++++++++++++++
 tb/tb_dmem_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_loader_pkg.sv
// Shared constants for the dmem loader: default widths and FSM state encoding.
package dmem_loader_pkg;
   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_ADDR_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } ld_state_e;
endpackage

// File: rtl/dmem_loader_byte_packer.sv
// byte_packer: assembles an MSB-first byte stream into DATA_W-bit words.
// word_rdy strobes in the cycle the last byte of a word is accepted; word is
// the completed value including that byte.
module byte_packer
   import dmem_loader_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_vld,
   input  logic [7:0]        in_byte,
   output logic              word_rdy,
   output logic [DATA_W-1:0] word
);
   localparam int NBYTES = DATA_W / 8;
   localparam int BCNT_W = $clog2(NBYTES + 1);

   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;

   // Shifted value as it will look once the current byte lands.
   generate
      if (NBYTES == 1) begin : g_one
         assign word = in_byte;
      end else begin : g_multi
         assign word = {shreg_q[DATA_W-9:0], in_byte};
      end
   endgenerate

   assign word_rdy = in_vld && (bcnt_q == BCNT_W'(NBYTES - 1));

   // Next-state for shift register and byte counter; counter restarts per word.
   always_comb begin
      shreg_d = shreg_q;
      bcnt_d  = bcnt_q;
      if (clr) begin
         shreg_d = '0;
         bcnt_d  = '0;
      end else if (in_vld) begin
         shreg_d = word;
         bcnt_d  = word_rdy ? '0 : bcnt_q + 1'b1;
      end
   end

   // Packer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
         bcnt_q  <= '0;
      end else begin
         shreg_q <= shreg_d;
         bcnt_q  <= bcnt_d;
      end
   end
endmodule

// File: rtl/dmem_loader.sv
// dmem_loader: streams bytes into consecutive dmem words from a base address.
// All outputs are registered. Optional running checksum of written words is
// enabled with the DMEM_LOADER_CHKSUM_EN macro; otherwise chksum is tied to 0.
module dmem_loader
   import dmem_loader_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_cnt,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] dm_a,
   output logic [DATA_W-1:0] dm_wd,
   output logic              dm_we,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] chksum
);
   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, rem_q, rem_d;
   logic [ADDR_W-1:0] dm_a_q, dm_a_d;
   logic [DATA_W-1:0] dm_wd_q, dm_wd_d;
   logic              in_ready_q, in_ready_d;
   logic              dm_we_q, dm_we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              go, accept, word_rdy;
   logic [DATA_W-1:0] word;

   assign go     = (state_q == ST_IDLE) && start;
   // in_ready_q is high exactly while in COLLECT.
   assign accept = in_valid && in_ready_q;

   byte_packer #(.DATA_W(DATA_W)) u_pack (
      .clk      (clk),
      .rst      (rst),
      .clr      (go),
      .in_vld   (accept),
      .in_byte  (in_data),
      .word_rdy (word_rdy),
      .word     (word)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; start outside IDLE is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = (word_cnt == '0) ? ST_DONE : ST_COLLECT;
         ST_COLLECT: if (word_rdy) state_d = ST_WRITE;
         ST_WRITE:   state_d = (rem_q == ADDR_W'(1)) ? ST_DONE : ST_COLLECT;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values, registered so they align with the state.
   always_comb begin
      addr_d     = addr_q;
      rem_d      = rem_q;
      dm_a_d     = dm_a_q;
      dm_wd_d    = dm_wd_q;
      in_ready_d = (state_d == ST_COLLECT);
      dm_we_d    = (state_d == ST_WRITE);
      busy_d     = (state_d == ST_COLLECT) || (state_d == ST_WRITE);
      done_d     = (state_d == ST_DONE);
      if (go) begin
         addr_d = base_addr;
         rem_d  = word_cnt;
      end
      if (state_q == ST_WRITE) begin
         addr_d = addr_q + 1'b1;
         rem_d  = rem_q - 1'b1;
      end
      if (word_rdy) begin
         dm_a_d  = addr_q;
         dm_wd_d = word;
      end
   end

   // Output and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         rem_q      <= '0;
         dm_a_q     <= '0;
         dm_wd_q    <= '0;
         in_ready_q <= 1'b0;
         dm_we_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         dm_a_q     <= dm_a_d;
         dm_wd_q    <= dm_wd_d;
         in_ready_q <= in_ready_d;
         dm_we_q    <= dm_we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

`ifdef DMEM_LOADER_CHKSUM_EN
   logic [DATA_W-1:0] chk_q, chk_d;

   // Running sum of written words; cleared on start, held after DONE.
   always_comb begin
      chk_d = chk_q;
      if (go)                        chk_d = '0;
      else if (state_q == ST_WRITE)  chk_d = chk_q + dm_wd_q;
   end

   // Checksum register.
   always_ff @(posedge clk) begin
      if (rst) chk_q <= '0;
      else     chk_q <= chk_d;
   end

   assign chksum = chk_q;
`else
   assign chksum = '0;
`endif

   assign in_ready = in_ready_q;
   assign dm_a     = dm_a_q;
   assign dm_wd    = dm_wd_q;
   assign dm_we    = dm_we_q;
   assign busy     = busy_q;
   assign done     = done_q;
endmodule

// File: tb/tb_dmem_loader.sv
// Randomized self-checking bench for dmem_loader with a scoreboard model.
module tb_dmem_loader;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] word_cnt = '0;
   logic [7:0]    in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready, dm_we, busy, done;
   logic [AW-1:0] dm_a;
   logic [DW-1:0] dm_wd, chksum;

   dmem_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .word_cnt(word_cnt), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .dm_a(dm_a), .dm_wd(dm_wd), .dm_we(dm_we),
      .busy(busy), .done(done), .chksum(chksum)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_acc_cyc = -10;
   int acc_in_word = 0;
   int done_cnt = 0;
   int wr_cnt = 0;
   logic [AW-1:0] exp_a[$];
   logic [DW-1:0] exp_d[$];
   logic [DW-1:0] mem [logic [AW-1:0]];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: scoreboard for writes and protocol checks, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         acc_in_word = 0;
      end else begin
         if (in_valid && in_ready) begin
            acc_in_word++;
            last_acc_cyc = cyc;
            chk("busy_on_xfer", busy, 1);
         end
         if (dm_we) begin
            chk("rdy_in_wr", in_ready, 0);
            chk("wr_lat", cyc - last_acc_cyc, 1);
            chk("wr_bytes", acc_in_word, NB);
            acc_in_word = 0;
            if (exp_a.size() == 0) chk("spurious_wr", 1, 0);
            else begin
               chk("wr_addr", dm_a, exp_a.pop_front());
               chk("wr_data", dm_wd, exp_d.pop_front());
            end
            mem[dm_a] = dm_wd;
            wr_cnt++;
         end
         if (done) done_cnt++;
      end
   end

   task automatic push_byte(input logic [7:0] b, input int mode);
      bit tog = 1'b0;
      bit hs;
      for (int g = 0; g < 200; g++) begin
         in_data  = b;
         in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         tog = ~tog;
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk); #1;
         if (hs) begin
            in_valid = 1'b0;
            return;
         end
      end
      chk("byte_timeout", 1, 0);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] c);
      base_addr = b;
      word_cnt  = c;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   // Runs a full load and checks it against the model built from the bytes.
   task automatic run_load(input logic [AW-1:0] b, input logic [AW-1:0] c,
                           input logic [7:0] bytes[$], input int mode);
      logic [DW-1:0] w;
      logic [DW-1:0] sum = '0;
      int d0 = done_cnt;
      int w0 = wr_cnt;
      bit seen = 0;
      for (int i = 0; i < int'(c); i++) begin
         w = '0;
         for (int k = 0; k < NB; k++) w = (w << 8) | DW'(bytes[i*NB+k]);
         exp_a.push_back(AW'(int'(b) + i));
         exp_d.push_back(w);
         sum += w;
      end
      pulse_start(b, c);
      for (int i = 0; i < int'(c) * NB; i++) push_byte(bytes[i], mode);
      for (int g = 0; g < 20 && !seen; g++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
`ifdef DMEM_LOADER_CHKSUM_EN
            chk("chksum", chksum, sum);
`else
            chk("chksum", chksum, 0);
`endif
            chk("busy_at_done", busy, 0);
         end
      end
      if (!seen) chk("done_timeout", 1, 0);
      repeat (2) @(negedge clk);
      chk("done_once", done_cnt - d0, 1);
      chk("wr_count", wr_cnt - w0, c);
      chk("wr_left", exp_a.size(), 0);
      exp_a.delete();
      exp_d.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] q[$];
      int lat;
      int w0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_we", dm_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_a", dm_a, 0);
      chk("rst_wd", dm_wd, 0);
      chk("rst_chk", chksum, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic load, then the same stream with in_valid toggling
      q = '{8'h07, 8'h0D, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
      run_load(16'h0000, 16'd2, q, 0);
      chk("mem0", mem[16'h0000], 32'h070d0001);
      chk("mem1", mem[16'h0001], 32'h00020003);
      mem.delete();
      run_load(16'h0000, 16'd2, q, 1);
      chk("bp_mem0", mem[16'h0000], 32'h070d0001);
      chk("bp_mem1", mem[16'h0001], 32'h00020003);

      // Zero count
      w0  = wr_cnt;
      lat = 0;
      pulse_start(16'h0010, 16'd0);
      lat = 1;
      @(negedge clk);
      while (!done && lat < 6) begin
         chk("zero_ready", in_ready, 0);
         @(negedge clk);
         lat++;
      end
      chk("zero_done", done, 1);
      chk("zero_lat_le2", (lat <= 2), 1);
      chk("zero_ready_done", in_ready, 0);
      repeat (3) @(negedge clk);
      chk("zero_no_wr", wr_cnt - w0, 0);
      @(posedge clk); #1;

      // Address wrap
      q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run_load(16'hFFFF, 16'd2, q, 2);
      chk("wrap_ffff", mem[16'hFFFF], 32'h01020304);
      chk("wrap_0000", mem[16'h0000], 32'h05060708);

      // Reset mid-word: three bytes of a word, then reset
      w0 = wr_cnt;
      pulse_start(16'h0020, 16'd2);
      for (int i = 0; i < 3; i++) push_byte(8'h11 * i, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_we", dm_we, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", in_ready, 0);
      repeat (3) @(negedge clk);
      chk("abort_no_wr", wr_cnt - w0, 0);
      @(posedge clk); #1;
      q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_load(16'h0004, 16'd1, q, 0);
      chk("abort_mem4", mem[16'h0004], 32'hAABBCCDD);

      // Checksum words 1, 2, FFFFFFFF (sum wraps to 2)
      q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
            8'hFF, 8'hFF, 8'hFF, 8'hFF};
      run_load(16'h0100, 16'd3, q, 0);

      // Random loads
      for (int t = 0; t < 8; t++) begin
         logic [AW-1:0] b;
         logic [AW-1:0] c;
         q.delete();
         b = (t == 0) ? 16'hFFFE : AW'($urandom);
         c = AW'($urandom_range(1, 4));
         for (int i = 0; i < int'(c) * NB; i++) q.push_back(8'($urandom));
         run_load(b, c, q, int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
